// File: rtl/core_mem_arbiter_pkg.sv
// Shared definitions for the core/memory arbiter: default sizes, FSM states
// and the per-core bus slicing helper.
package core_mem_arbiter_pkg;

   localparam int unsigned CMA_NUM_CORES = 16;
   localparam int unsigned CMA_ADDR_W    = 8;
   localparam int unsigned CMA_DATA_W    = 8;
   localparam int unsigned CMA_LAT_W     = 3;   // holds MEM_LAT values 1..4

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2
   } arb_state_t;

   // LSB of core `core` inside a packed per-core bus of `width`-bit slices.
   function automatic int unsigned slice_lsb(input int unsigned core,
                                             input int unsigned width);
      return core * width;
   endfunction

endpackage

// File: rtl/core_mem_arbiter_if.sv
// Core-side request bus plus memory-side bus of the shared memory arbiter.
interface core_mem_arbiter_if
   import core_mem_arbiter_pkg::*;
#(
   parameter int unsigned NUM_CORES = CMA_NUM_CORES,
   parameter int unsigned ADDR_W    = CMA_ADDR_W,
   parameter int unsigned DATA_W    = CMA_DATA_W
);
   logic [NUM_CORES-1:0]        req;
   logic [NUM_CORES-1:0]        we;
   logic [NUM_CORES*ADDR_W-1:0] addr;
   logic [NUM_CORES*DATA_W-1:0] wdata;
   logic                        hold;
   logic [NUM_CORES-1:0]        gnt;
   logic [NUM_CORES-1:0]        rvalid;
   logic [DATA_W-1:0]           rdata;
   logic                        mem_en;
   logic                        mem_we;
   logic [ADDR_W-1:0]           mem_addr;
   logic [DATA_W-1:0]           mem_wdata;
   logic [DATA_W-1:0]           mem_rdata;
   logic                        busy;

   modport slave (
      input  req, we, addr, wdata, hold, mem_rdata,
      output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
   );

   modport master (
      output req, we, addr, wdata, hold, mem_rdata,
      input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
   );

endinterface

// File: rtl/core_mem_arbiter_rr_priority_pick.sv
// Round-robin pick: first set request bit at or after ptr, wrapping around.
module rr_priority_pick #(
   parameter int unsigned N    = 16,
   parameter int unsigned IDXW = $clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [IDXW-1:0] ptr,
   output logic [IDXW-1:0] idx,
   output logic            found
);

   logic [2*N-1:0] dbl;

   // Lower half keeps only requests at/above ptr, upper half holds all of
   // them, so the lowest set bit of the double vector is the wrapped winner.
   always_comb begin
      dbl   = '0;
      idx   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         dbl[i]     = req[i] && (i >= 32'(ptr));
         dbl[i + N] = req[i];
      end
      for (int unsigned i = 0; i < 2 * N; i++) begin
         if (dbl[i] && !found) begin
            found = 1'b1;
            idx   = IDXW'(i % N);
         end
      end
   end

endmodule

// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the cores.
// One access at a time: IDLE -> ISSUE (write) or IDLE -> ISSUE -> WAIT (read).
module core_mem_arbiter
   import core_mem_arbiter_pkg::*;
#(
   parameter int unsigned NUM_CORES = CMA_NUM_CORES,
   parameter int unsigned ADDR_W    = CMA_ADDR_W,
   parameter int unsigned DATA_W    = CMA_DATA_W,
   parameter int unsigned MEM_LAT   = 1
) (
   input  logic              clk,
   input  logic              reset,
   core_mem_arbiter_if.slave bus
);

   localparam int unsigned           IDXW    = $clog2(NUM_CORES);
   localparam logic [IDXW-1:0]       LAST    = IDXW'(NUM_CORES - 1);
   localparam logic [CMA_LAT_W-1:0]  LAT_END = CMA_LAT_W'(MEM_LAT);

   arb_state_t             state_q, state_d;
   logic [IDXW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [IDXW-1:0]        idx_q, idx_d;
   logic                   we_q, we_d;
   logic [CMA_LAT_W-1:0]   lat_q, lat_d;
   logic [NUM_CORES-1:0]   gnt_q, gnt_d;
   logic [NUM_CORES-1:0]   rvalid_q, rvalid_d;
   logic [DATA_W-1:0]      rdata_q, rdata_d;
   logic                   mem_en_q, mem_en_d;
   logic                   mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;

   logic [IDXW-1:0]        pick_idx;
   logic                   pick_found;

   rr_priority_pick #(
      .N    (NUM_CORES),
      .IDXW (IDXW)
   ) u_pick (
      .req   (bus.req),
      .ptr   (rr_ptr_q),
      .idx   (pick_idx),
      .found (pick_found)
   );

   // Next-state and registered-output decode for the arbitration FSM.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      idx_d       = idx_q;
      we_d        = we_q;
      lat_d       = lat_q;
      gnt_d       = '0;
      rvalid_d    = '0;
      rdata_d     = rdata_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      unique case (state_q)
         ARB_IDLE: begin
            if (!bus.hold && pick_found) begin
               idx_d          = pick_idx;
               we_d           = bus.we[pick_idx];
               mem_addr_d     = bus.addr[slice_lsb(32'(pick_idx), ADDR_W) +: ADDR_W];
               mem_wdata_d    = bus.wdata[slice_lsb(32'(pick_idx), DATA_W) +: DATA_W];
               gnt_d[pick_idx] = 1'b1;
               mem_en_d       = 1'b1;
               mem_we_d       = bus.we[pick_idx];
               state_d        = ARB_ISSUE;
            end
         end
         ARB_ISSUE: begin
            rr_ptr_d = (idx_q == LAST) ? '0 : idx_q + 1'b1;
            if (we_q) begin
               state_d = ARB_IDLE;
            end else begin
               state_d = ARB_WAIT;
               lat_d   = CMA_LAT_W'(1);
            end
         end
         ARB_WAIT: begin
            if (lat_q == LAT_END) state_d = ARB_IDLE;
            else                  lat_d   = lat_q + 1'b1;
         end
         default: state_d = ARB_IDLE;
      endcase

      // rdata/rvalid are registered, so they are loaded on the edge that
      // enters the final WAIT cycle; the pulse is then visible in that cycle.
      if (state_d == ARB_WAIT && lat_d == LAT_END) begin
         rvalid_d[idx_d] = 1'b1;
         rdata_d         = bus.mem_rdata;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ARB_IDLE;
         rr_ptr_q    <= '0;
         idx_q       <= '0;
         we_q        <= 1'b0;
         lat_q       <= '0;
         gnt_q       <= '0;
         rvalid_q    <= '0;
         rdata_q     <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         idx_q       <= idx_d;
         we_q        <= we_d;
         lat_q       <= lat_d;
         gnt_q       <= gnt_d;
         rvalid_q    <= rvalid_d;
         rdata_q     <= rdata_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.rvalid    = rvalid_q;
   assign bus.rdata     = rdata_q;
   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.busy      = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter (16 cores, 8-bit bus, MEM_LAT=2).
module tb_core_mem_arbiter;

   localparam int unsigned NC = 16;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_bad;

   core_mem_arbiter_if #(.NUM_CORES(NC), .ADDR_W(8), .DATA_W(8)) ifc ();

   core_mem_arbiter #(
      .NUM_CORES (NC),
      .ADDR_W    (8),
      .DATA_W    (8),
      .MEM_LAT   (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous RAM with one register stage: data sampled by the arbiter
   // at the second edge after mem_en.
   logic [7:0] mem [256];
   logic [7:0] rd_q;
   always @(posedge clk) begin
      if (ifc.mem_en) begin
         if (ifc.mem_we) mem[ifc.mem_addr] <= ifc.mem_wdata;
         else            rd_q <= mem[ifc.mem_addr];
      end
   end
   assign ifc.mem_rdata = rd_q;

   typedef struct {
      int         core;
      logic       we;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_rdata;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_core(input int c, input logic w, input logic [7:0] a, input logic [7:0] d);
      ifc.we[c]          = w;
      ifc.addr[c*8 +: 8] = a;
      ifc.wdata[c*8 +: 8] = d;
   endtask

   task automatic wait_gnt(input string name, input logic [31:0] exp);
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < 8 && !seen; c++) begin
         step();
         if (ifc.gnt != '0) begin
            seen = 1'b1;
            chk(name, 32'(ifc.gnt), exp);
         end
      end
      if (!seen) chk({name, " timeout"}, 32'(ifc.gnt), exp);
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, " gnt"},       32'(ifc.gnt),       32'h0);
      chk({tag, " rvalid"},    32'(ifc.rvalid),    32'h0);
      chk({tag, " rdata"},     32'(ifc.rdata),     32'h0);
      chk({tag, " mem_en"},    32'(ifc.mem_en),    32'h0);
      chk({tag, " mem_we"},    32'(ifc.mem_we),    32'h0);
      chk({tag, " mem_addr"},  32'(ifc.mem_addr),  32'h0);
      chk({tag, " mem_wdata"}, 32'(ifc.mem_wdata), 32'h0);
      chk({tag, " busy"},      32'(ifc.busy),      32'h0);
   endtask

   task automatic run_vec(input vec_t t, input int v);
      string n;
      n = $sformatf("v%0d", v);
      ifc.req = '0;
      set_core(t.core, t.we, t.addr, t.wdata);
      ifc.req[t.core] = 1'b1;
      step();
      chk({n, " gnt"},      32'(ifc.gnt),      32'(1) << t.core);
      chk({n, " mem_en"},   32'(ifc.mem_en),   32'h1);
      chk({n, " mem_we"},   32'(ifc.mem_we),   32'(t.we));
      chk({n, " mem_addr"}, 32'(ifc.mem_addr), 32'(t.addr));
      chk({n, " busy"},     32'(ifc.busy),     32'h1);
      chk({n, " rvalid"},   32'(ifc.rvalid),   32'h0);
      if (t.we) chk({n, " mem_wdata"}, 32'(ifc.mem_wdata), 32'(t.wdata));
      ifc.req[t.core] = 1'b0;
      if (t.we) begin
         step();
         chk({n, " gnt end"},  32'(ifc.gnt),    32'h0);
         chk({n, " busy end"}, 32'(ifc.busy),   32'h0);
         chk({n, " rv end"},   32'(ifc.rvalid), 32'h0);
      end else begin
         step();
         chk({n, " rv wait1"},   32'(ifc.rvalid), 32'h0);
         chk({n, " busy wait1"}, 32'(ifc.busy),   32'h1);
         step();
         chk({n, " rvalid"},     32'(ifc.rvalid), 32'(1) << t.core);
         chk({n, " rdata"},      32'(ifc.rdata),  32'(t.exp_rdata));
         chk({n, " busy wait2"}, 32'(ifc.busy),   32'h1);
         step();
         chk({n, " rv end"},     32'(ifc.rvalid), 32'h0);
         chk({n, " busy end"},   32'(ifc.busy),   32'h0);
         chk({n, " rdata hold"}, 32'(ifc.rdata),  32'(t.exp_rdata));
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h3C;
      rd_q      = 8'h00;
      reset     = 1'b1;
      ifc.req   = '0;
      ifc.we    = '0;
      ifc.addr  = '0;
      ifc.wdata = '0;
      ifc.hold  = 1'b0;

      vecs[0] = '{core: 3,  we: 1'b1, addr: 8'h10, wdata: 8'hA5, exp_rdata: 8'h00};
      vecs[1] = '{core: 5,  we: 1'b0, addr: 8'h10, wdata: 8'h00, exp_rdata: 8'hA5};
      vecs[2] = '{core: 0,  we: 1'b1, addr: 8'h20, wdata: 8'h5A, exp_rdata: 8'h00};
      vecs[3] = '{core: 15, we: 1'b0, addr: 8'h20, wdata: 8'h00, exp_rdata: 8'h5A};
      vecs[4] = '{core: 7,  we: 1'b0, addr: 8'h33, wdata: 8'h00, exp_rdata: 8'h0F};
      vecs[5] = '{core: 15, we: 1'b1, addr: 8'hFF, wdata: 8'h81, exp_rdata: 8'h00};
      vecs[6] = '{core: 15, we: 1'b0, addr: 8'hFF, wdata: 8'h00, exp_rdata: 8'h81};

      // Reset state
      repeat (3) step();
      check_idle_outputs("reset");
      reset = 1'b0;
      step();

      // Single transactions from the table
      for (int v = 0; v < 7; v++) run_vec(vecs[v], v);

      // All cores reading continuously: strict 0..15,0 order
      for (int c = 0; c < int'(NC); c++) set_core(c, 1'b0, 8'(c), 8'h00);
      ifc.req = '1;
      for (int g = 0; g <= int'(NC); g++)
         wait_gnt($sformatf("rr grant %0d", g), 32'(1) << (g % int'(NC)));
      ifc.req = '0;
      repeat (4) step();

      // Wrap at the last core: move pointer to 15, then 15 and 0 compete
      set_core(14, 1'b1, 8'h90, 8'h11);
      ifc.req = 16'h4000;
      wait_gnt("ptr setup c14", 32'h4000);
      ifc.req = '0;
      step();
      set_core(15, 1'b1, 8'h91, 8'h22);
      set_core(0,  1'b1, 8'h92, 8'h33);
      ifc.req = 16'h8001;
      wait_gnt("wrap first c15", 32'h8000);
      ifc.req[15] = 1'b0;
      wait_gnt("wrap then c0", 32'h0001);
      ifc.req[0] = 1'b0;
      step();

      // hold blocks grants; hold rising during WAIT does not abort the read
      set_core(2, 1'b0, 8'h42, 8'h00);
      set_core(7, 1'b0, 8'h77, 8'h00);
      ifc.hold = 1'b1;
      ifc.req  = 16'h0084;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("hold gnt %0d", i), 32'(ifc.gnt), 32'h0);
      end
      ifc.hold = 1'b0;
      step();
      chk("hold release gnt2", 32'(ifc.gnt), 32'h0004);
      ifc.req[2] = 1'b0;
      step();
      ifc.hold = 1'b1;
      chk("hold wait1 rv", 32'(ifc.rvalid), 32'h0);
      step();
      chk("hold rvalid2", 32'(ifc.rvalid), 32'h0004);
      chk("hold rdata2",  32'(ifc.rdata),  32'h7E);
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("hold2 gnt %0d", i), 32'(ifc.gnt), 32'h0);
      end
      ifc.hold = 1'b0;
      step();
      chk("hold release gnt7", 32'(ifc.gnt), 32'h0080);
      ifc.req[7] = 1'b0;
      step();
      step();
      chk("c7 rvalid", 32'(ifc.rvalid), 32'h0080);
      chk("c7 rdata",  32'(ifc.rdata),  32'h4B);
      step();

      // Reset during a read WAIT abandons it and clears the pointer
      set_core(9, 1'b0, 8'h50, 8'h00);
      ifc.req = 16'h0200;
      step();
      chk("c9 gnt", 32'(ifc.gnt), 32'h0200);
      ifc.req = '0;
      step();
      reset = 1'b1;
      step();
      check_idle_outputs("mid reset");
      reset = 1'b0;
      step();
      chk("post reset rvalid", 32'(ifc.rvalid), 32'h0);
      chk("post reset busy",   32'(ifc.busy),   32'h0);
      set_core(15, 1'b1, 8'hA0, 8'h01);
      set_core(1,  1'b1, 8'hA1, 8'h02);
      ifc.req = 16'h8002;
      wait_gnt("ptr zero after reset", 32'h0002);
      ifc.req = '0;
      repeat (2) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
- Round-robin arbiter that shares one single-port memory (shared data/frame memory) between all cores started by the task scheduler.
- Each core issues one read or write at a time through a req/gnt handshake; reads return through a per-core rvalid pulse.
- A hold input lets the display path freeze new grants while it scans the memory, mirroring the scheduler's VGA stop window.

Parameters:
- NUM_CORES, 16, number of requesting cores.
- ADDR_W, 8, memory address width.
- DATA_W, 8, memory data width.
- MEM_LAT, 1, memory read latency in cycles (1..4), from mem_en to valid mem_rdata.

Ports:
- clk  in  1  single clock; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_CORES  per-core request.
- we  in  NUM_CORES  per-core write enable; 0 means read.
- addr  in  NUM_CORES*ADDR_W  per-core address; core i uses slice [i*ADDR_W +: ADDR_W].
- wdata  in  NUM_CORES*DATA_W  per-core write data, sliced the same way.
- hold  in  1  block new grants; an in-flight access completes.
- gnt  out  NUM_CORES  one-hot grant pulse.
- rvalid  out  NUM_CORES  one-hot read-data-valid pulse.
- rdata  out  DATA_W  read data, shared by all cores, qualified by rvalid.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset:
  - state=IDLE, rr_ptr=0.
  - gnt, rvalid, mem_en, mem_we, busy = 0; rdata, mem_addr, mem_wdata = 0.
  - Reset mid-access abandons the access; no rvalid is issued.
- Requester rules:
  - req/we/addr/wdata are held stable until gnt is sampled high.
  - req is dropped at that same edge; req high in the following IDLE cycle is a new request.
- IDLE:
  - If hold=0 and req!=0, pick the first set bit scanning rr_ptr, rr_ptr+1, ..., wrapping mod NUM_CORES.
  - Register idx, we[idx], addr slice and wdata slice; go to ISSUE.
  - If hold=1 or req==0, stay in IDLE.
- ISSUE (1 cycle):
  - Outputs: gnt[idx]=1, mem_en=1, mem_we=latched we, mem_addr and mem_wdata from latched values.
  - rr_ptr <= (idx+1) mod NUM_CORES.
  - Write: next state IDLE. Read: next state WAIT, with lat_cnt=1.
- WAIT:
  - lat_cnt counts up each cycle.
  - When lat_cnt==MEM_LAT, capture mem_rdata into rdata, assert rvalid[idx]=1 for that one cycle, then go to IDLE.
  - For MEM_LAT=1 the capture happens in the first WAIT cycle.
- Timing and throughput:
  - Write: 2 cycles per transaction (IDLE, ISSUE).
  - Read: 2+MEM_LAT cycles; rvalid appears MEM_LAT cycles after the gnt cycle.
- All outputs are registered except busy, which is decoded from state.
- rdata holds its last value between rvalid pulses.
- Fairness:
  - Under continuous requests from all cores, each core is granted once every NUM_CORES grants.
  - A single requester is granted back-to-back; rr_ptr still advances.
- Boundaries:
  - idx = NUM_CORES-1 wraps rr_ptr to 0.
  - Requests arriving while busy wait for IDLE; none are lost or queued beyond the req level.
  - hold rising during ISSUE or WAIT does not abort the access.
  - hold falling enables arbitration in the same IDLE cycle.
  - No combinational path from req to gnt.

Decomposition:
- Add to the shared ranges/defines include:
  - core count and address/data widths;
  - per-core slice range macros for addr and wdata;
  - state encodings ARB_IDLE, ARB_ISSUE, ARB_WAIT.
- One natural combinational sub-module, rr_priority_pick:
  - inputs: req vector, rr_ptr;
  - outputs: idx and a found flag;
  - implementation: double-width masked priority encoder.

Test Plan:
- Reset, then core 3 writes addr=0x10, data=0xA5 -> gnt[3] one cycle after req; mem_en=1, mem_we=1, mem_addr=0x10, mem_wdata=0xA5 in that cycle; rvalid stays 0.
- Core 5 reads addr=0x10 with MEM_LAT=2 and memory returning 0xA5 -> gnt[5] at cycle t; rvalid[5]=1 and rdata=0xA5 at t+2; busy high from t through t+2.
- All 16 cores request reads continuously -> grant order 0,1,...,15,0; no core granted twice within any 16 consecutive grants.
- rr_ptr=15 with cores 15 and 0 both requesting -> core 15 granted first, then core 0.
- hold=1 while cores 2 and 7 request -> no gnt; release hold -> gnt[2] in the next cycle; hold raised during core 2's read WAIT -> rvalid[2] still delivered, core 7 not granted until hold=0.
- reset asserted in WAIT of a read -> next cycle state IDLE with all outputs 0; no rvalid; rr_ptr=0.
